if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry FIFO of {pc, inst} pairs between fetch and decode, using valid/ready handshakes on both sides. It decouples fetch from decode stalls, and a synchronous flush discards wrong-path instructions on branch redirect. When the queue is empty, decode sees a bubble (zero pc, zero inst).

Parameters:
ADDR_W, 32, instruction address width (matches `InstAddrBus).
INST_W, 32, instruction word width (matches `InstBus).
DEPTH, 4, number of entries; power of 2, >= 2.
CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous discard of all entries (branch/exception redirect)
if_valid  input  1  fetch presents a valid {if_pc, if_inst}
if_ready  output  1  queue can accept this cycle
if_pc  input  ADDR_W  fetched pc
if_inst  input  INST_W  fetched instruction
id_valid  output  1  head entry valid
id_ready  input  1  decode consumes head this cycle (deasserted = stall)
id_pc  output  ADDR_W  head pc; `ZeroInstAddr when empty
id_inst  output  INST_W  head instruction; `ZeroInst when empty
count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0 -> id_valid=0, id_pc=`ZeroInstAddr, id_inst=`ZeroInst, if_ready=1. Storage contents are don't-care. Reset mid-operation drops all entries immediately.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count is tracked separately, so full and empty are unambiguous.
- push = if_valid & if_ready; pop = id_valid & id_ready.
- if_ready = (count != DEPTH) (base build). Combinational from state only; no dependency on if_valid.
- id_valid = (count != 0). id_pc/id_inst = mem[rd_ptr] when id_valid, otherwise the zero constants (bubble).
- Latency: an entry pushed in cycle N is visible at id_* in cycle N+1. There is no same-cycle bypass.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pop with id_ready=1 on an empty queue: no effect, no pointer movement.
- flush=1 (synchronous, highest priority after rst): pointers and count go to 0 at the next edge. Any push or pop in that cycle is ignored, so the entry presented by fetch in the flush cycle is discarded. if_ready is not gated by flush.
- Ordering is strict FIFO; entries are never reordered or dropped except by flush or rst.
- No state machine beyond the pointers and count. Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, with count==DEPTH when the pointers are equal and the queue is full.

Optional Feature:
IFQ_FULL_PASS_EN
- Defined: if_ready = (count != DEPTH) | id_ready. A full queue accepts a push in the same cycle it pops; count stays DEPTH and both pointers advance. This adds a combinational id_ready -> if_ready path.
- Undefined: if_ready depends only on count, so a full queue stalls fetch for one cycle even when decode pops.

Decomposition:
- Shared defines header: `ZeroInstAddr, `ZeroInst, `InstAddrBus, `InstBus, plus a new `IfqDepth default constant.
- The rst-active level is fixed high here and is not derived from `RstEnable.
- One natural sub-module: ifq_mem, a DEPTH x (ADDR_W+INST_W) register array with one write port (we, waddr, wdata) and one async read port (raddr, rdata), no reset.
- Pointer and count logic stays in the top.

Test Plan:
- Reset then idle: rst pulse; expect id_valid=0, id_pc=0, id_inst=0, count=0, if_ready=1.
- Fill and drain with DEPTH=4, id_ready=0: push pc 0x100,0x104,0x108,0x10C; expect count=4 and if_ready=0. Then set id_ready=1; expect id_pc 0x100,0x104,0x108,0x10C on consecutive cycles, then bubble.
- Simultaneous push and pop at count=2: count stays 2 across 10 cycles of streaming pc 0x200+4k. Output order matches input order, and rd_ptr wraps past 3 -> 0.
- Flush with push in the same cycle at count=3: next cycle count=0 and id_valid=0. The flush-cycle pc 0x300 never appears; a push of 0x400 in the following cycle appears one cycle later.
- Async reset mid-stream at count=2: outputs go to zero before the next clk edge; after deassertion the queue accepts normally.
- Full-pass build: IFQ_FULL_PASS_EN defined, count=4, id_ready=1, if_valid=1; expect if_ready=1 and count=4. Undefined: expect if_ready=0 and count goes to 3.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared fetch/decode constants and queue defaults
`ifndef IF_ID_QUEUE_DEFINES
`define IF_ID_QUEUE_DEFINES
`define InstAddrBus  31:0
`define InstBus      31:0
`define ZeroInstAddr 32'h0
`define ZeroInst     32'h0
`define IfqDepth     4
`endif

package if_id_queue_pkg;
    localparam int IFQ_ADDR_W_DEFAULT = 32;
    localparam int IFQ_INST_W_DEFAULT = 32;
    localparam int IFQ_DEPTH_DEFAULT  = `IfqDepth;
endpackage

// File: rtl/if_id_queue_mem.sv
// rtl/if_id_queue_mem.sv - DEPTH-entry register array, one write port, async read
module ifq_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem_q [DEPTH];

    // No reset: occupancy is tracked by the pointers, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID FIFO of {pc, inst}; IFQ_FULL_PASS_EN lets a full queue push while popping
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W  = IFQ_ADDR_W_DEFAULT,
    parameter int INST_W  = IFQ_INST_W_DEFAULT,
    parameter int DEPTH   = IFQ_DEPTH_DEFAULT,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int DW    = ADDR_W + INST_W;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, full;
    logic [DW-1:0]    rdata;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign id_valid = (count_q != '0);
`ifdef IFQ_FULL_PASS_EN
    assign if_ready = ~full | id_ready;
`else
    assign if_ready = ~full;
`endif
    assign push  = if_valid & if_ready;
    assign pop   = id_valid & id_ready;
    assign count = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    ifq_mem #(.DEPTH(DEPTH), .W(DW)) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr_q),
        .wdata ({if_pc, if_inst}),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Empty queue presents a bubble rather than stale storage.
    assign id_pc   = id_valid ? rdata[DW-1:INST_W] : ADDR_W'(`ZeroInstAddr);
    assign id_inst = id_valid ? rdata[INST_W-1:0]  : INST_W'(`ZeroInst);
endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue
`timescale 1ns/1ps
module tb_if_id_queue;
    logic        clk = 1'b0;
    logic        rst, flush, if_valid, id_ready;
    logic        if_ready, id_valid;
    logic [31:0] if_pc, if_inst, id_pc, id_inst;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

`ifdef IFQ_FULL_PASS_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    always #5 clk = ~clk;

    if_id_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
        .count(count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    // Scoreboard: compare at negedge, then apply the handshakes the coming edge will take.
    always @(negedge clk) begin
        int n;
        logic exp_rdy;
        if (rst) begin
            sb.delete();
        end else begin
            n = sb.size();
            exp_rdy = (n != 4) || (FP && id_ready);
            check("count", 64'(count), 64'(n));
            check("id_valid", 64'(id_valid), 64'(n != 0));
            check("if_ready", 64'(if_ready), 64'(exp_rdy));
            if (n != 0) begin
                check("id_pc", 64'(id_pc), 64'(sb[0][63:32]));
                check("id_inst", 64'(id_inst), 64'(sb[0][31:0]));
            end else begin
                check("bubble_pc", 64'(id_pc), 64'h0);
                check("bubble_inst", 64'(id_inst), 64'h0);
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (n != 0 && id_ready) void'(sb.pop_front());
                if (if_valid && exp_rdy) sb.push_back({if_pc, inst_of(if_pc)});
            end
        end
    end

    // Called at posedge+1: present inputs for one cycle.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst_of(pc);
        id_ready = rdy;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_pc = '0; if_inst = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(id_valid), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_ready", 64'(if_ready), 64'h1);
        check("rst_pc", 64'(id_pc), 64'h0);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // fill and drain
        for (int k = 0; k < 4; k++) step(1'b1, 32'h100 + 32'(4 * k), 1'b0, 1'b0);
        check("fill_count", 64'(count), 64'h4);
        check("fill_ready", 64'(if_ready), 64'h0);
        drain();
        check("drain_valid", 64'(id_valid), 64'h0);

        // streaming at count=2, wraps the pointers
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'h208 + 32'(4 * k), 1'b1, 1'b0);
            check("stream_count", 64'(count), 64'h2);
        end
        drain();

        // flush with a push in the same cycle
        for (int k = 0; k < 3; k++) step(1'b1, 32'h280 + 32'(4 * k), 1'b0, 1'b0);
        check("preflush_count", 64'(count), 64'h3);
        step(1'b1, 32'h300, 1'b0, 1'b1);
        check("flush_count", 64'(count), 64'h0);
        check("flush_valid", 64'(id_valid), 64'h0);
        step(1'b1, 32'h400, 1'b0, 1'b0);
        check("postflush_pc", 64'(id_pc), 64'h400);
        drain();

        // async reset mid-stream
        step(1'b1, 32'h480, 1'b0, 1'b0);
        step(1'b1, 32'h484, 1'b0, 1'b0);
        if_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(id_valid), 64'h0);
        check("arst_count", 64'(count), 64'h0);
        check("arst_pc", 64'(id_pc), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1'b1, 32'h500, 1'b0, 1'b0);
        check("after_arst_pc", 64'(id_pc), 64'h500);
        drain();

        // full queue with decode popping
        for (int k = 0; k < 4; k++) step(1'b1, 32'h580 + 32'(4 * k), 1'b0, 1'b0);
        if_valid = 1'b1; if_pc = 32'h600; if_inst = inst_of(32'h600); id_ready = 1'b1;
        #1;
        check("fullpass_ready", 64'(if_ready), 64'(FP));
        @(posedge clk);
        #1;
        check("fullpass_count", 64'(count), FP ? 64'h4 : 64'h3);
        if_valid = 1'b0;
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("end_empty", 64'(id_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
